// File: rtl/mem_stage_pkg.sv
// Shared types for the MEM pipeline stage: op encodings, stage payloads,
// byte-enable constants and the access FSM states.
package mem_stage_pkg;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned REG_AW = 5;

    typedef logic [REG_AW-1:0] regaddr_t;

    typedef enum logic [3:0] {
        MEM_OP_NONE = 4'd0,
        MEM_OP_LB   = 4'd1,
        MEM_OP_LBU  = 4'd2,
        MEM_OP_LH   = 4'd3,
        MEM_OP_LHU  = 4'd4,
        MEM_OP_LW   = 4'd5,
        MEM_OP_SB   = 4'd6,
        MEM_OP_SH   = 4'd7,
        MEM_OP_SW   = 4'd8
    } mem_op_t;

    typedef struct packed {
        regaddr_t        rd_addr;
        logic [XLEN-1:0] rd_data;
        mem_op_t         mem_op;
        logic [XLEN-1:0] mem_data;
    } mem_params_t;

    typedef struct packed {
        regaddr_t        rd_addr;
        logic [XLEN-1:0] rd_data;
    } wb_params_t;

    localparam logic [3:0] BE_NONE    = 4'b0000;
    localparam logic [3:0] BE_BYTE0   = 4'b0001;
    localparam logic [3:0] BE_LO_HALF = 4'b0011;
    localparam logic [3:0] BE_HI_HALF = 4'b1100;
    localparam logic [3:0] BE_WORD    = 4'b1111;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_REQ  = 1'b1
    } state_t;

    function automatic logic is_store_op(mem_op_t op);
        return (op == MEM_OP_SB) || (op == MEM_OP_SH) || (op == MEM_OP_SW);
    endfunction

endpackage

// File: rtl/mem_stage_align.sv
// Combinational lane logic: store byte enables and replicated data,
// alignment check, and load-lane extraction with sign/zero extension.
module mem_stage_align
    import mem_stage_pkg::*;
(
    input  logic [31:0] i_addr,
    input  mem_op_t     i_op,
    input  logic [31:0] i_wdata,
    input  logic [31:0] i_rdata,
    output logic [3:0]  o_be_c,
    output logic [31:0] o_wdata_c,
    output logic        o_misaligned_c,
    output logic [31:0] o_load_c
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = i_rdata[7:0];
        case (i_addr[1:0])
            2'd1:    w_byte = i_rdata[15:8];
            2'd2:    w_byte = i_rdata[23:16];
            2'd3:    w_byte = i_rdata[31:24];
            default: w_byte = i_rdata[7:0];
        endcase
        w_half = i_addr[1] ? i_rdata[31:16] : i_rdata[15:0];
    end

    always_comb begin
        o_be_c         = BE_NONE;
        o_wdata_c      = '0;
        o_misaligned_c = 1'b0;
        o_load_c       = '0;
        case (i_op)
            MEM_OP_LB:  o_load_c = {{24{w_byte[7]}}, w_byte};
            MEM_OP_LBU: o_load_c = {24'd0, w_byte};
            MEM_OP_LH: begin
                o_load_c       = {{16{w_half[15]}}, w_half};
                o_misaligned_c = i_addr[0];
            end
            MEM_OP_LHU: begin
                o_load_c       = {16'd0, w_half};
                o_misaligned_c = i_addr[0];
            end
            MEM_OP_LW: begin
                o_load_c       = i_rdata;
                o_misaligned_c = (i_addr[1:0] != 2'd0);
            end
            MEM_OP_SB: begin
                o_be_c    = 4'(BE_BYTE0 << i_addr[1:0]);
                o_wdata_c = {4{i_wdata[7:0]}};
            end
            MEM_OP_SH: begin
                o_be_c         = i_addr[1] ? BE_HI_HALF : BE_LO_HALF;
                o_wdata_c      = {2{i_wdata[15:0]}};
                o_misaligned_c = i_addr[0];
            end
            MEM_OP_SW: begin
                o_be_c         = BE_WORD;
                o_wdata_c      = i_wdata;
                o_misaligned_c = (i_addr[1:0] != 2'd0);
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: issues one outstanding load/store on the req/ack bus,
// stalls upstream while waiting, and flags misaligned accesses and timeouts.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  mem_params_t mem_params_in,
    output regaddr_t    wb_rd_addr,
    output logic [31:0] wb_rd_data,
    output logic        stall,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic        exc_misaligned,
    output logic        exc_bus_err,
    output logic [31:0] exc_addr
);

    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    state_t            r_state, w_state_nxt;
    logic              r_req, w_req_nxt;
    logic              r_we, w_we_nxt;
    logic [31:0]       r_addr, w_addr_nxt;
    logic [3:0]        r_be, w_be_nxt;
    logic [31:0]       r_wdata, w_wdata_nxt;
    logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
    mem_op_t           r_op, w_op_nxt;
    regaddr_t          r_rd, w_rd_nxt;
    logic [31:0]       r_eff, w_eff_nxt;
    wb_params_t        r_wb, w_wb_nxt;
    logic              r_exc_mis, w_exc_mis_nxt;
    logic              r_exc_bus, w_exc_bus_nxt;
    logic [31:0]       r_exc_addr, w_exc_addr_nxt;
    logic              w_stall;

    logic [31:0]       w_al_addr;
    mem_op_t           w_al_op;
    logic [3:0]        w_be;
    logic [31:0]       w_wdata;
    logic              w_misaligned;
    logic [31:0]       w_load;

    // While a request is in flight, extraction uses the captured access.
    assign w_al_addr = (r_state == ST_REQ) ? r_eff : mem_params_in.rd_data;
    assign w_al_op   = (r_state == ST_REQ) ? r_op  : mem_params_in.mem_op;

    mem_stage_align u_align (
        .i_addr         (w_al_addr),
        .i_op           (w_al_op),
        .i_wdata        (mem_params_in.mem_data),
        .i_rdata        (dmem_rdata),
        .o_be_c         (w_be),
        .o_wdata_c      (w_wdata),
        .o_misaligned_c (w_misaligned),
        .o_load_c       (w_load)
    );

    always_comb begin
        w_state_nxt    = r_state;
        w_req_nxt      = r_req;
        w_we_nxt       = r_we;
        w_addr_nxt     = r_addr;
        w_be_nxt       = r_be;
        w_wdata_nxt    = r_wdata;
        w_cnt_nxt      = r_cnt;
        w_op_nxt       = r_op;
        w_rd_nxt       = r_rd;
        w_eff_nxt      = r_eff;
        w_wb_nxt       = '0;
        w_exc_mis_nxt  = 1'b0;
        w_exc_bus_nxt  = 1'b0;
        w_exc_addr_nxt = r_exc_addr;
        w_stall        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (mem_params_in.mem_op == MEM_OP_NONE) begin
                    w_wb_nxt.rd_addr = mem_params_in.rd_addr;
                    w_wb_nxt.rd_data = mem_params_in.rd_data;
                end else if (w_misaligned) begin
                    w_exc_mis_nxt  = 1'b1;
                    w_exc_addr_nxt = mem_params_in.rd_data;
                end else begin
                    w_stall     = 1'b1;
                    w_req_nxt   = 1'b1;
                    w_we_nxt    = is_store_op(mem_params_in.mem_op);
                    w_addr_nxt  = {mem_params_in.rd_data[31:2], 2'b00};
                    w_be_nxt    = w_be;
                    w_wdata_nxt = w_wdata;
                    w_cnt_nxt   = '0;
                    w_op_nxt    = mem_params_in.mem_op;
                    w_rd_nxt    = mem_params_in.rd_addr;
                    w_eff_nxt   = mem_params_in.rd_data;
                    w_state_nxt = ST_REQ;
                end
            end
            ST_REQ: begin
                if (dmem_ack) begin
                    w_req_nxt   = 1'b0;
                    w_state_nxt = ST_IDLE;
                    if (!is_store_op(r_op)) begin
                        w_wb_nxt.rd_addr = r_rd;
                        w_wb_nxt.rd_data = w_load;
                    end
                end else if (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    w_req_nxt      = 1'b0;
                    w_exc_bus_nxt  = 1'b1;
                    w_exc_addr_nxt = r_eff;
                    w_state_nxt    = ST_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                    w_stall   = 1'b1;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_req      <= 1'b0;
            r_we       <= 1'b0;
            r_addr     <= '0;
            r_be       <= '0;
            r_wdata    <= '0;
            r_cnt      <= '0;
            r_op       <= MEM_OP_NONE;
            r_rd       <= '0;
            r_eff      <= '0;
            r_wb       <= '0;
            r_exc_mis  <= 1'b0;
            r_exc_bus  <= 1'b0;
            r_exc_addr <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_req      <= w_req_nxt;
            r_we       <= w_we_nxt;
            r_addr     <= w_addr_nxt;
            r_be       <= w_be_nxt;
            r_wdata    <= w_wdata_nxt;
            r_cnt      <= w_cnt_nxt;
            r_op       <= w_op_nxt;
            r_rd       <= w_rd_nxt;
            r_eff      <= w_eff_nxt;
            r_wb       <= w_wb_nxt;
            r_exc_mis  <= w_exc_mis_nxt;
            r_exc_bus  <= w_exc_bus_nxt;
            r_exc_addr <= w_exc_addr_nxt;
        end
    end

    // Stall is forced low during reset so upstream is released immediately.
    assign stall          = rst_n & w_stall;
    assign dmem_req       = r_req;
    assign dmem_we        = r_we;
    assign dmem_addr      = r_addr;
    assign dmem_be        = r_be;
    assign dmem_wdata     = r_wdata;
    assign wb_rd_addr     = r_wb.rd_addr;
    assign wb_rd_data     = r_wb.rd_data;
    assign exc_misaligned = r_exc_mis;
    assign exc_bus_err    = r_exc_bus;
    assign exc_addr       = r_exc_addr;

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- MEM pipeline stage; consumes mem_params_t from the EX/MEM register and produces writeback parameters for the MEM/WB register.
- Drives a single-outstanding req/ack data-memory bus, performing loads and stores.
- Stalls upstream while an access is in flight.
- Detects misaligned accesses and bus timeouts.

Parameters:
- TIMEOUT_CYCLES, 255: maximum wait-for-ack cycles in REQ before a bus error is raised; must be >= 1.

Ports:
- clk  in  1  clock; all state updates on posedge
- rst_n  in  1  asynchronous active-low reset
- mem_params_in  in  mem_params_t  rd_addr, rd_data (ALU result; effective address for memory ops), mem_op, mem_data (store data)
- wb_rd_addr  out  regaddr_t  writeback destination; 0 = no write
- wb_rd_data  out  32  writeback value
- stall  out  1  hold EX/MEM and earlier stages
- dmem_req  out  1  bus request, registered
- dmem_we  out  1  1 = store
- dmem_addr  out  32  word-aligned address (addr[1:0] = 0)
- dmem_be  out  4  byte enables
- dmem_wdata  out  32  lane-replicated store data
- dmem_ack  in  1  access complete; rdata valid same cycle
- dmem_rdata  in  32  load word
- exc_misaligned  out  1  one-cycle pulse
- exc_bus_err  out  1  one-cycle pulse
- exc_addr  out  32  faulting effective address; held until next exception

Behaviour:
- Reset is asynchronous and active-low: clk, rst_n.
- Reset values: state IDLE, wb_rd_addr 0, wb_rd_data 0, dmem_req 0, dmem_we 0, dmem_addr 0, dmem_be 0, dmem_wdata 0, exc_* 0, exc_addr 0, timeout counter 0.
- mem_op encodings: NONE, LB, LBU, LH, LHU, LW, SB, SH, SW.
- FSM states: IDLE, REQ.
- IDLE, mem_op = NONE:
  - wb_rd_addr/wb_rd_data <= rd_addr/rd_data.
  - stall = 0.
  - 1-cycle latency.
- IDLE, memory op, aligned:
  - stall = 1 (combinational).
  - Next edge: dmem_req <= 1; addr/be/we/wdata registered; counter cleared; state <= REQ.
  - Output bubble: wb_rd_addr <= 0.
- IDLE, memory op, misaligned (H with addr[0] = 1; W with addr[1:0] != 0):
  - No request issued; stall = 0.
  - Next edge: exc_misaligned <= 1 for one cycle; exc_addr <= addr; bubble.
- REQ:
  - dmem_req and all bus outputs held stable until ack.
  - stall = ~dmem_ack.
- REQ, on ack:
  - Next edge: dmem_req <= 0; state <= IDLE.
  - Load: wb_rd_addr <= rd_addr; wb_rd_data <= extracted lane (see extraction rules).
  - Store: wb_rd_addr <= 0.
  - Upstream advances on the same edge (stall low in ack cycle).
- REQ, no ack:
  - Counter increments each cycle.
  - When counter == TIMEOUT_CYCLES-1 without ack: next edge drops req, pulses exc_bus_err, exc_addr <= addr, bubble, state IDLE, stall low that cycle.
- Load extraction:
  - Byte: lane = addr[1:0]; LB sign-extends, LBU zero-extends.
  - Half: lane = addr[1]; LH sign-extends, LHU zero-extends.
- Store lane mapping:
  - be: SB = 1<<addr[1:0]; SH = 0011 or 1100; SW = 1111.
  - wdata: byte replicated x4, half x2.
- Minimum load latency: 2 cycles (ack in first REQ cycle); stalled cycles emit bubbles.
- Late input: dmem_ack while in IDLE is ignored.
- rd_addr = 0 on a load: the access is still performed; writeback stays suppressed (addr 0).
- Reset mid-REQ: dmem_req drops immediately (async); any in-flight ack is ignored after reset.

Decomposition:
- Package types holds:
  - mem_op_t enum covering the mem_op encodings (extending MEM_OP_NONE)
  - mem_params_t
  - new wb_params_t {rd_addr, rd_data}
  - BE_* constants
- Sub-module mem_align, combinational: effective address + op + mem_data/rdata -> be, wdata, misaligned, load result.
- mem_stage instantiates mem_align and holds the FSM/counter.

Test Plan:
- mem_op NONE, rd_addr 5, rd_data 0x1234 -> next cycle wb_rd_addr 5, wb_rd_data 0x1234; stall never high.
- LB addr 0x103, ack on 1st REQ cycle, rdata 0x80FF_0000 -> dmem_addr 0x100, be 0000, we 0; wb_rd_data 0xFFFF_FF80; stall high exactly 1 cycle.
- SH addr 0x202, mem_data 0xABCD_1234, ack after 3 cycles -> be 1100, wdata 0x1234_1234, req held 3 cycles, wb_rd_addr 0, stall high 3 cycles.
- LW addr 0x301 -> no dmem_req, exc_misaligned 1 cycle, exc_addr 0x301, wb_rd_addr 0.
- TIMEOUT_CYCLES = 4, LW addr 0x400, no ack -> req high 4 cycles then drops, exc_bus_err 1 cycle, exc_addr 0x400.
- rst_n low during REQ -> dmem_req, stall, wb_* at 0 immediately; ack after release ignored.
